// File: rtl/tlb_ctrl.sv
// TLB controller for an externally stored 4-way set-associative TLB.
// It handles lookup, page-walk refill, LRU-count victim selection and flush sequencing.
module tlb_ctrl #(
  parameter int unsigned NUM_SETS       = 16,
  parameter int unsigned SET_INDEX_BITS = 4,
  parameter int unsigned LRU_BITS       = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [31:0]                 req_va,
  input  logic                        req_write,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [31:0]                 resp_pa,
  output logic                        resp_fault,
  output logic                        walk_req_valid,
  input  logic                        walk_req_ready,
  output logic [19:0]                 walk_req_vpn,
  input  logic                        walk_resp_valid,
  input  logic [19:0]                 walk_ppn,
  input  logic [1:0]                  walk_perms,
  input  logic                        walk_fault,
  input  logic                        flush,
  output logic [SET_INDEX_BITS-1:0]   st_rd_set_index,
  input  logic [3:0]                  st_rd_valid,
  input  logic [79:0]                 st_rd_vpn,
  input  logic [79:0]                 st_rd_ppn,
  input  logic [7:0]                  st_rd_perms,
  input  logic [4*LRU_BITS-1:0]       st_rd_lru,
  output logic                        st_wr_en,
  output logic                        st_update_en,
  output logic                        st_lru_update_en,
  output logic [SET_INDEX_BITS-1:0]   st_wr_set_index,
  output logic [1:0]                  st_wr_way,
  output logic                        st_wr_valid,
  output logic [19:0]                 st_wr_vpn,
  output logic [19:0]                 st_wr_ppn,
  output logic [1:0]                  st_wr_perms,
  output logic [LRU_BITS-1:0]         st_wr_lru,
  output logic [SET_INDEX_BITS-1:0]   st_lru_set_index,
  output logic [1:0]                  st_lru_way
);

  localparam int unsigned NUM_WAYS   = 4;
  localparam int unsigned VPN_W      = 20;
  localparam int unsigned PPN_W      = 20;
  localparam int unsigned PERM_W     = 2;
  localparam int unsigned CNT_W      = SET_INDEX_BITS + 2;
  localparam int unsigned FLUSH_LAST = 4 * NUM_SETS - 1;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP, FLUSH
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               va_q, va_d;
  logic                      write_q, write_d;
  logic [PPN_W-1:0]          ppn_q, ppn_d;
  logic [PERM_W-1:0]         perms_q, perms_d;
  logic [1:0]                victim_q, victim_d;
  logic [31:0]               pa_q, pa_d;
  logic                      fault_q, fault_d;
  logic                      flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;

  logic [VPN_W-1:0]          vpn_c;
  logic [SET_INDEX_BITS-1:0] set_c;
  logic                      hit;
  logic [1:0]                hit_way;
  logic [PPN_W-1:0]          hit_ppn;
  logic [PERM_W-1:0]         hit_perms;
  logic [LRU_BITS-1:0]       hit_lru;
  logic                      vic_inv;
  logic [1:0]                victim;
  logic [LRU_BITS-1:0]       min_lru;
  logic [LRU_BITS-1:0]       way_lru;

  assign vpn_c = va_q[31:12];
  assign set_c = va_q[12 +: SET_INDEX_BITS];

  // Hit detection (lowest matching way) and victim choice from the read set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    hit_ppn   = '0;
    hit_perms = '0;
    hit_lru   = '0;
    vic_inv   = 1'b0;
    victim    = '0;
    min_lru   = st_rd_lru[0 +: LRU_BITS];
    way_lru   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && st_rd_valid[w] && st_rd_vpn[w*VPN_W +: VPN_W] == vpn_c) begin
        hit       = 1'b1;
        hit_way   = 2'(w);
        hit_ppn   = st_rd_ppn[w*PPN_W +: PPN_W];
        hit_perms = st_rd_perms[w*PERM_W +: PERM_W];
        hit_lru   = st_rd_lru[w*LRU_BITS +: LRU_BITS];
      end
      if (!vic_inv && !st_rd_valid[w]) begin
        vic_inv = 1'b1;
        victim  = 2'(w);
      end
    end
    if (!vic_inv) begin
      for (int w = 1; w < NUM_WAYS; w++) begin
        way_lru = st_rd_lru[w*LRU_BITS +: LRU_BITS];
        if (way_lru < min_lru) begin
          min_lru = way_lru;
          victim  = 2'(w);
        end
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    va_d             = va_q;
    write_d          = write_q;
    ppn_d            = ppn_q;
    perms_d          = perms_q;
    victim_d         = victim_q;
    pa_d             = pa_q;
    fault_d          = fault_q;
    flush_pend_d     = flush_pend_q;
    cnt_d            = cnt_q;
    st_wr_en         = 1'b0;
    st_update_en     = 1'b0;
    st_lru_update_en = 1'b0;
    st_wr_set_index  = '0;
    st_wr_way        = '0;
    st_wr_valid      = 1'b0;
    st_wr_vpn        = '0;
    st_wr_ppn        = '0;
    st_wr_perms      = '0;
    st_wr_lru        = '0;
    st_lru_set_index = '0;
    st_lru_way       = '0;

    if (flush && state_q != IDLE && state_q != FLUSH) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) begin
          flush_pend_d = 1'b0;
          cnt_d        = '0;
          state_d      = FLUSH;
        end else if (req_valid) begin
          va_d    = req_va;
          write_d = req_write;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        victim_d = victim;
        if (hit) begin
          pa_d    = {hit_ppn, va_q[11:0]};
          fault_d = write_q ? !hit_perms[1] : !hit_perms[0];
          // A saturated usage counter is left alone rather than wrapped
          if (hit_lru != '1) begin
            st_wr_en         = 1'b1;
            st_lru_update_en = 1'b1;
            st_lru_set_index = set_c;
            st_lru_way       = hit_way;
          end
          state_d = RESP;
        end else begin
          state_d = WALK_REQ;
        end
      end
      WALK_REQ: begin
        if (walk_req_ready) state_d = WALK_WAIT;
      end
      WALK_WAIT: begin
        if (walk_resp_valid) begin
          if (walk_fault) begin
            pa_d    = '0;
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            ppn_d   = walk_ppn;
            perms_d = walk_perms;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        st_wr_en        = 1'b1;
        st_update_en    = 1'b1;
        st_wr_set_index = set_c;
        st_wr_way       = victim_q;
        st_wr_valid     = 1'b1;
        st_wr_vpn       = vpn_c;
        st_wr_ppn       = ppn_q;
        st_wr_perms     = perms_q;
        pa_d            = {ppn_q, va_q[11:0]};
        fault_d         = write_q ? !perms_q[1] : !perms_q[0];
        state_d         = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      FLUSH: begin
        // Counter walks (set, way) way-minor; every field written as zero
        st_wr_en        = 1'b1;
        st_update_en    = 1'b1;
        st_wr_set_index = cnt_q[CNT_W-1:2];
        st_wr_way       = cnt_q[1:0];
        cnt_d           = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(FLUSH_LAST)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      va_q         <= '0;
      write_q      <= 1'b0;
      ppn_q        <= '0;
      perms_q      <= '0;
      victim_q     <= '0;
      pa_q         <= '0;
      fault_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      va_q         <= va_d;
      write_q      <= write_d;
      ppn_q        <= ppn_d;
      perms_q      <= perms_d;
      victim_q     <= victim_d;
      pa_q         <= pa_d;
      fault_q      <= fault_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
    end
  end

  // A same-cycle flush blocks the handshake because flush wins over a request
  assign req_ready       = (state_q == IDLE) && !flush_pend_q && !flush;
  assign resp_valid      = (state_q == RESP);
  assign resp_pa         = pa_q;
  assign resp_fault      = fault_q;
  assign walk_req_valid  = (state_q == WALK_REQ);
  assign walk_req_vpn    = vpn_c;
  assign st_rd_set_index = set_c;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Bench for tlb_ctrl: behavioural storage, walker and TLB reference model.
// It runs directed scenarios followed by randomized traffic.
module tb_tlb_ctrl;
  localparam int unsigned NS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_va = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_fault;
  logic [31:0] resp_pa;
  logic        walk_req_valid, walk_req_ready = 1'b0;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid = 1'b0, walk_fault = 1'b0;
  logic [19:0] walk_ppn = '0;
  logic [1:0]  walk_perms = '0;
  logic        flush = 1'b0;
  logic [3:0]  st_rd_set_index;
  logic [3:0]  st_rd_valid;
  logic [79:0] st_rd_vpn, st_rd_ppn;
  logic [7:0]  st_rd_perms;
  logic [15:0] st_rd_lru;
  logic        st_wr_en, st_update_en, st_lru_update_en, st_wr_valid;
  logic [3:0]  st_wr_set_index, st_lru_set_index, st_wr_lru;
  logic [1:0]  st_wr_way, st_wr_perms, st_lru_way;
  logic [19:0] st_wr_vpn, st_wr_ppn;

  always #5 clk = ~clk;

  tlb_ctrl #(.NUM_SETS(16), .SET_INDEX_BITS(4), .LRU_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_va(req_va), .req_write(req_write),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pa(resp_pa), .resp_fault(resp_fault),
    .walk_req_valid(walk_req_valid), .walk_req_ready(walk_req_ready), .walk_req_vpn(walk_req_vpn),
    .walk_resp_valid(walk_resp_valid), .walk_ppn(walk_ppn), .walk_perms(walk_perms),
    .walk_fault(walk_fault), .flush(flush),
    .st_rd_set_index(st_rd_set_index), .st_rd_valid(st_rd_valid), .st_rd_vpn(st_rd_vpn),
    .st_rd_ppn(st_rd_ppn), .st_rd_perms(st_rd_perms), .st_rd_lru(st_rd_lru),
    .st_wr_en(st_wr_en), .st_update_en(st_update_en), .st_lru_update_en(st_lru_update_en),
    .st_wr_set_index(st_wr_set_index), .st_wr_way(st_wr_way), .st_wr_valid(st_wr_valid),
    .st_wr_vpn(st_wr_vpn), .st_wr_ppn(st_wr_ppn), .st_wr_perms(st_wr_perms), .st_wr_lru(st_wr_lru),
    .st_lru_set_index(st_lru_set_index), .st_lru_way(st_lru_way)
  );

  // Entry storage owned by the bench, written only from the posedge process
  logic        s_valid [NS][4];
  logic [19:0] s_vpn   [NS][4];
  logic [19:0] s_ppn   [NS][4];
  logic [1:0]  s_perms [NS][4];
  logic [3:0]  s_lru   [NS][4];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_set = '0, pl_lru = '0;
  logic [1:0]  pl_way = '0;
  logic [19:0] pl_vpn = '0;
  int upd_cnt = 0, lru_cnt = 0, both_cnt = 0;

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      st_rd_valid[w]         = s_valid[st_rd_set_index][w];
      st_rd_vpn[w*20 +: 20]  = s_vpn[st_rd_set_index][w];
      st_rd_ppn[w*20 +: 20]  = s_ppn[st_rd_set_index][w];
      st_rd_perms[w*2 +: 2]  = s_perms[st_rd_set_index][w];
      st_rd_lru[w*4 +: 4]    = s_lru[st_rd_set_index][w];
    end
  end

  always @(posedge clk) begin
    if (pl_en) begin
      s_valid[pl_set][pl_way] <= 1'b1;
      s_vpn[pl_set][pl_way]   <= pl_vpn;
      s_ppn[pl_set][pl_way]   <= pl_vpn ^ 20'hF0F0F;
      s_perms[pl_set][pl_way] <= 2'b11;
      s_lru[pl_set][pl_way]   <= pl_lru;
    end
    if (st_wr_en && st_update_en) begin
      s_valid[st_wr_set_index][st_wr_way] <= st_wr_valid;
      s_vpn[st_wr_set_index][st_wr_way]   <= st_wr_vpn;
      s_ppn[st_wr_set_index][st_wr_way]   <= st_wr_ppn;
      s_perms[st_wr_set_index][st_wr_way] <= st_wr_perms;
      s_lru[st_wr_set_index][st_wr_way]   <= st_wr_lru;
      upd_cnt <= upd_cnt + 1;
    end
    if (st_wr_en && st_lru_update_en) begin
      s_lru[st_lru_set_index][st_lru_way] <= s_lru[st_lru_set_index][st_lru_way] + 4'd1;
      lru_cnt <= lru_cnt + 1;
    end
    if (st_update_en && st_lru_update_en) both_cnt <= both_cnt + 1;
  end

  // Reference TLB contents
  logic        r_valid [NS][4];
  logic [19:0] r_vpn   [NS][4];
  logic [19:0] r_ppn   [NS][4];
  logic [1:0]  r_perms [NS][4];
  logic [3:0]  r_lru   [NS][4];

  int tests = 0, fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ref_clear();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 4; w++) begin
        r_valid[s][w] = 1'b0; r_vpn[s][w] = '0; r_ppn[s][w] = '0;
        r_perms[s][w] = '0;   r_lru[s][w] = '0;
      end
  endtask

  function automatic int pick_victim(input logic [3:0] s);
    int best;
    for (int w = 0; w < 4; w++) if (!r_valid[s][w]) return w;
    best = 0;
    for (int w = 1; w < 4; w++) if (r_lru[s][w] < r_lru[s][best]) best = w;
    return best;
  endfunction

  task automatic chk_set(input logic [3:0] s);
    for (int w = 0; w < 4; w++)
      chk($sformatf("entry_s%0d_w%0d", s, w),
          64'({s_valid[s][w], s_vpn[s][w], s_ppn[s][w], s_perms[s][w], s_lru[s][w]}),
          64'({r_valid[s][w], r_vpn[s][w], r_ppn[s][w], r_perms[s][w], r_lru[s][w]}));
  endtask

  task automatic preload(input int s, input int w, input logic [19:0] vpn, input logic [3:0] lru);
    pl_en = 1'b1; pl_set = 4'(s); pl_way = 2'(w); pl_vpn = vpn; pl_lru = lru;
    @(negedge clk);
    pl_en = 1'b0;
    r_valid[s][w] = 1'b1; r_vpn[s][w] = vpn; r_ppn[s][w] = vpn ^ 20'hF0F0F;
    r_perms[s][w] = 2'b11; r_lru[s][w] = lru;
  endtask

  // Waits for flush completion; n counts negedges from the call until req_ready
  task automatic wait_flush(input int exp_cycles, input logic reflush);
    int upd0, n, nz;
    upd0 = upd_cnt; n = 0;
    while (!req_ready && n < 300) begin
      flush = reflush && (n == 10);
      @(negedge clk); n++;
    end
    flush = 1'b0;
    chk("flush_timeout", 64'(n < 300), 64'd1);
    chk("flush_cycles", 64'(n), 64'(exp_cycles));
    chk("flush_writes", 64'(upd_cnt - upd0), 64'd64);
    nz = 0;
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < 4; w++)
        if ({s_valid[s][w], s_vpn[s][w], s_ppn[s][w], s_perms[s][w], s_lru[s][w]} !== '0) nz++;
    chk("flush_cleared", 64'(nz), 64'd0);
    ref_clear();
    @(negedge clk);
    chk("flush_once", 64'({req_ready, 32'(upd_cnt - upd0)}), 64'({1'b1, 32'd64}));
  endtask

  // One full request with model prediction, walker emulation and response checks
  task automatic run_req(input logic [31:0] va, input logic wr, input logic [19:0] wppn,
                         input logic [1:0] wperms, input logic wflt, input logic inj_flush);
    logic [19:0] vpn;
    logic [3:0]  s;
    logic        e_miss, e_flt, walked, fl_done;
    logic [31:0] e_pa;
    int hw, vic, e_upd, e_lru, upd0, lru0, n, cyc, ph, d;
    vpn = va[31:12]; s = vpn[3:0];
    hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && r_valid[s][w] && r_vpn[s][w] == vpn) hw = w;
    e_upd = 0; e_lru = 0;
    if (hw >= 0) begin
      e_miss = 1'b0;
      e_pa   = {r_ppn[s][hw], va[11:0]};
      e_flt  = !(wr ? r_perms[s][hw][1] : r_perms[s][hw][0]);
      if (r_lru[s][hw] != 4'hF) begin r_lru[s][hw] = r_lru[s][hw] + 4'd1; e_lru = 1; end
    end else begin
      e_miss = 1'b1;
      if (wflt) begin
        e_pa = '0; e_flt = 1'b1;
      end else begin
        vic = pick_victim(s);
        r_valid[s][vic] = 1'b1; r_vpn[s][vic] = vpn; r_ppn[s][vic] = wppn;
        r_perms[s][vic] = wperms; r_lru[s][vic] = '0;
        e_pa  = {wppn, va[11:0]};
        e_flt = !(wr ? wperms[1] : wperms[0]);
        e_upd = 1;
      end
    end
    upd0 = upd_cnt; lru0 = lru_cnt;
    req_va = va; req_write = wr; req_valid = 1'b1; n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    chk("req_ready_wait", 64'(n < 200), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; ph = 0; d = int'($urandom_range(0, 2)); walked = 1'b0; fl_done = 1'b0;
    while (!resp_valid && cyc < 400) begin
      walk_req_ready = 1'b0; walk_resp_valid = 1'b0; flush = 1'b0;
      if (walk_req_valid) begin
        chk("walk_vpn", 64'(walk_req_vpn), 64'(vpn));
        walked = 1'b1;
        if (d == 0) begin walk_req_ready = 1'b1; ph = 1; d = int'($urandom_range(0, 3)); end
        else d--;
      end else if (ph == 1) begin
        if (inj_flush && !fl_done) begin flush = 1'b1; fl_done = 1'b1; end
        if (d == 0) begin
          walk_resp_valid = 1'b1; walk_ppn = wppn; walk_perms = wperms; walk_fault = wflt; ph = 2;
        end else d--;
      end
      @(negedge clk); cyc++;
    end
    walk_req_ready = 1'b0; walk_resp_valid = 1'b0; flush = 1'b0;
    chk("resp_timeout", 64'(cyc < 400), 64'd1);
    chk("walked", 64'(walked), 64'(e_miss));
    if (!e_miss) chk("hit_latency", 64'(cyc), 64'd2);
    chk("resp_pa", 64'(resp_pa), 64'(e_pa));
    chk("resp_fault", 64'(resp_fault), 64'(e_flt));
    repeat (int'($urandom_range(0, 2))) begin
      @(negedge clk);
      chk("resp_hold", 64'({resp_valid, resp_pa, resp_fault}), 64'({1'b1, e_pa, e_flt}));
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", 64'(resp_valid), 64'd0);
    chk("upd_pulses", 64'(upd_cnt - upd0), 64'(e_upd));
    chk("lru_pulses", 64'(lru_cnt - lru0), 64'(e_lru));
    if (!inj_flush) chk_set(s);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int upd0, n;
    logic [19:0] rv;
    ref_clear();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_walk_valid", 64'(walk_req_valid), 64'd0);
    chk("rst_strobes", 64'({st_wr_en, st_update_en, st_lru_update_en}), 64'd0);
    chk("rst_resp_data", 64'({resp_pa, resp_fault}), 64'd0);

    // Flush from IDLE, with a second flush pulse arriving mid-flush
    flush = 1'b1;
    @(negedge clk);
    wait_flush(64, 1'b1);

    // Miss and refill, then hit on the same page
    run_req(32'h0001_2345, 1'b0, 20'h000AB, 2'b01, 1'b0, 1'b0);
    chk("refill_s2_w0", 64'({s_valid[2][0], s_vpn[2][0], s_ppn[2][0]}),
        64'({1'b1, 20'h00012, 20'h000AB}));
    run_req(32'h0001_2345, 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);
    chk("hit_lru_s2_w0", 64'(s_lru[2][0]), 64'd1);

    // Store to a read-only entry
    run_req(32'h0001_2678, 1'b1, 20'h0, 2'b00, 1'b0, 1'b0);

    // Victim selection: full set by minimum count, and lowest invalid way
    preload(5, 0, 20'h10005, 4'd3);
    preload(5, 1, 20'h20005, 4'd1);
    preload(5, 2, 20'h30005, 4'd1);
    preload(5, 3, 20'h40005, 4'd5);
    run_req(32'h5000_5ABC, 1'b0, 20'h11111, 2'b11, 1'b0, 1'b0);
    chk("victim_min_lru", 64'(s_vpn[5][1]), 64'h50005);
    preload(6, 0, 20'h10006, 4'd0);
    preload(6, 1, 20'h20006, 4'd0);
    preload(6, 3, 20'h30006, 4'd0);
    run_req(32'h5000_6123, 1'b0, 20'h22222, 2'b11, 1'b0, 1'b0);
    chk("victim_invalid", 64'(s_vpn[6][2]), 64'h50006);

    // Walker fault
    run_req(32'h0077_7000, 1'b0, 20'h33333, 2'b11, 1'b1, 1'b0);

    // Flush during the walk: request completes, then flush, then the page misses
    run_req(32'h0009_9123, 1'b0, 20'h00123, 2'b11, 1'b0, 1'b1);
    chk("flush_pending_blocks_req", 64'(req_ready), 64'd0);
    wait_flush(65, 1'b0);
    run_req(32'h0009_9123, 1'b0, 20'h00456, 2'b11, 1'b0, 1'b0);

    // Reset in the middle of a walk; a late walker strobe must be ignored
    req_va = 32'h00AA_A000; req_write = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; n = 0;
    while (!walk_req_valid && n < 20) begin @(negedge clk); n++; end
    chk("rst_walk_reached", 64'(walk_req_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_walk_drop", 64'({walk_req_valid, resp_valid}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    upd0 = upd_cnt;
    walk_resp_valid = 1'b1; walk_ppn = 20'h99999; walk_perms = 2'b11; walk_fault = 1'b0;
    @(negedge clk);
    walk_resp_valid = 1'b0;
    @(negedge clk);
    chk("rst_late_walk", 64'({req_ready, resp_valid, walk_req_valid}), 64'b100);
    chk("rst_late_no_write", 64'(upd_cnt - upd0), 64'd0);
    chk_set(4'hA);

    // Hit on a saturated usage counter
    preload(9, 1, 20'h12349, 4'hF);
    run_req(32'h1234_9555, 1'b0, 20'h0, 2'b00, 1'b0, 1'b0);

    // Randomized traffic over a small page pool so hits and evictions occur
    for (int i = 0; i < 40; i++) begin
      rv = {16'(16'h0040 + 16'($urandom_range(0, 5))), 4'($urandom_range(0, 3))};
      run_req({rv, 12'($urandom)}, 1'($urandom_range(0, 1)), 20'($urandom),
              2'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
    end

    chk("strobe_exclusive", 64'(both_cnt), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 Parameters SHALL be:
- NUM_SETS, 16, number of TLB sets.
- SET_INDEX_BITS, 4, log2(NUM_SETS).
- LRU_BITS, 4, width of the per-way usage counter.
- NUM_WAYS is fixed at 4, matching the 2-bit way select.

REQ-002 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.

REQ-003 Ports SHALL be:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid / req_ready  in / out  1 / 1  translation request handshake.
- req_va  in  32  virtual address; vpn = va[31:12], set = vpn[SET_INDEX_BITS-1:0].
- req_write  in  1  access type: 1 = store, 0 = load.
- resp_valid / resp_ready  out / in  1 / 1  response handshake.
- resp_pa  out  32  physical address {ppn, va[11:0]}.
- resp_fault  out  1  page-walk fault or permission fault.
- walk_req_valid / walk_req_ready  out / in  1 / 1  page-walker request handshake.
- walk_req_vpn  out  20  VPN to walk.
- walk_resp_valid  in  1  one-cycle walker result strobe.
- walk_ppn / walk_perms / walk_fault  in  20 / 2 / 1  walker result.
- flush  in  1  single-cycle pulse requesting invalidation of all entries.
- st_rd_set_index  out  SET_INDEX_BITS  storage read set.
- st_rd_valid/vpn/ppn/perms/lru  in  4 / 80 / 80 / 8 / 4*LRU_BITS  packed per-way storage read data, way w at [w*W +: W].
- st_wr_en, st_update_en, st_lru_update_en  out  1 each  storage write strobes.
- st_wr_set_index/way/valid/vpn/ppn/perms/lru  out  SET_INDEX_BITS / 2 / 1 / 20 / 20 / 2 / LRU_BITS  storage entry write.
- st_lru_set_index / st_lru_way  out  SET_INDEX_BITS / 2  storage LRU increment target.

Function
REQ-004 FSM states SHALL be IDLE, LOOKUP, WALK_REQ, WALK_WAIT, REFILL, RESP, FLUSH.

REQ-005 req_ready SHALL be 1 only in IDLE with no flush pending.
- On req_valid & req_ready: capture va and write; go to LOOKUP.

REQ-006 In LOOKUP, st_rd_set_index SHALL equal the captured set.
- hit = any way with valid and vpn equal to the captured vpn.
- Lowest-numbered matching way wins.

REQ-007 LOOKUP hit: permission check, then go to RESP.
- Permission check: perms[0] = read, perms[1] = write; fault if the required bit is 0.
- In the same cycle, pulse st_wr_en = st_lru_update_en = 1 for the hit way.
- Suppress the pulse if that way's lru count is all ones (saturation).

REQ-008 LOOKUP miss: go to WALK_REQ.
- Hold walk_req_valid = 1 and walk_req_vpn stable until walk_req_ready.
- Then go to WALK_WAIT.

REQ-009 In WALK_WAIT, on walk_resp_valid:
- walk_fault = 1: go to RESP with resp_fault = 1, resp_pa = 0, no refill.
- Otherwise: go to REFILL.

REQ-010 Victim way: lowest-numbered invalid way; else the way with the minimum lru count, ties to the lowest index.
- Victim is computed from LOOKUP read data and registered.

REQ-011 REFILL SHALL last one cycle.
- st_wr_en = st_update_en = 1, valid = 1, captured vpn, walk_ppn, walk_perms, lru = 0.
- Go to RESP; the response applies the permission check to walk_perms.

REQ-012 In RESP, resp_valid SHALL be 1 with resp_pa / resp_fault stable until resp_ready, then go to IDLE.

REQ-013 Hit latency SHALL be accept cycle + 1 (resp_valid two cycles after the accepting edge, assuming resp_ready = 1).

REQ-014 flush arriving in any non-IDLE state SHALL set a pending flag.
- Flush is taken in IDLE, with priority over req_valid.
- In FLUSH, write valid = 0 and all fields 0 to one (set, way) per cycle, way-minor, sets 0 to NUM_SETS-1.
- Takes exactly 4*NUM_SETS cycles, then returns to IDLE.
- flush during FLUSH is ignored.

REQ-015 All strobes not named for a state SHALL be 0 in that state; st_lru_update_en and st_update_en are never both 1.

Reset
REQ-016 rst_n low SHALL asynchronously force IDLE and clear the pending flush, counters and captured fields.
- Outputs: req_ready = 1 after release, resp_valid = 0, walk_req_valid = 0, all storage strobes = 0, resp_pa = 0, resp_fault = 0.
- A walk response arriving after reset mid-walk SHALL be ignored in IDLE.

Verification
REQ-017 Miss then hit:
- Load va 0x00012345, walker returns ppn 0x000AB, perms 2'b01 -> refill set 2 way 0, resp_pa 0x000AB345, fault 0.
- Repeat -> hit, resp two cycles after accept, lru increment set 2 way 0.

REQ-018 Store to an entry with perms 2'b01 -> resp_fault = 1, entry unchanged.

REQ-019 Set full with lru {3,1,1,5} -> victim way 1; set with way 2 invalid -> victim way 2.

REQ-020 walk_fault = 1 -> resp_fault = 1, resp_pa = 0, no st_update_en pulse.

REQ-021 flush during WALK_WAIT -> request completes first, then 64 FLUSH write cycles.
- Next lookup of the same va misses.

REQ-022 rst_n low during WALK_REQ -> walk_req_valid drops immediately, IDLE after release.
- Hit on an entry with lru count 15 -> no st_lru_update_en pulse.
